// File: rtl/full_subtractor_if.sv
// Operand/result bundle for the registered full subtractor.
// Valid-only handshake: in_valid qualifies a/b/bin for one edge, and out_valid marks d/bout one cycle later. There is no ready, so the slice accepts one operation every cycle.
interface full_subtractor_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             out_valid;

  modport master (
    output in_valid, a, b, bin,
    input  d, bout, out_valid
  );

  modport slave (
    input  in_valid, a, b, bin,
    output d, bout, out_valid
  );
endinterface

// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor slice: {bout, d} = a - b - bin, one cycle latency.
// bin and bout chain to neighbouring slices when wider subtractors are built from several of these.
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  full_subtractor_if.slave    bus
);

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] diff;

  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             out_valid_q;

  assign br[0] = bus.bin;

  // br[i] is the borrow into bit i. It ripples upward from bin.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign diff[i]  = bus.a[i] ^ bus.b[i] ^ br[i];
    assign br[i+1]  = (~bus.a[i] & bus.b[i]) |
                      (~bus.a[i] & br[i])    |
                      ( bus.b[i] & br[i]);
  end

  // d/bout are loaded only on accepted operations, so unqualified inputs never reach the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q         <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        d_q    <= diff;
        bout_q <= br[WIDTH];
      end
    end
  end

  assign bus.d         = d_q;
  assign bus.bout      = bout_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor at WIDTH=1 and WIDTH=8.
// The reference model computes results directly as unsigned subtraction and comparison.
module tb_full_subtractor;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  logic [2:0] exp1_q[$];   // {out_valid, bout, d} for the 1-bit slice
  logic [9:0] exp8_q[$];   // {out_valid, bout, d} for the 8-bit slice

  full_subtractor_if #(.WIDTH(1)) bus1 ();
  full_subtractor_if #(.WIDTH(8)) bus8 ();

  full_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  full_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  // reference model: borrow is an unsigned compare, difference is modular subtraction
  function automatic logic [8:0] ref8(input int unsigned a, input int unsigned b, input int unsigned bin);
    int unsigned diff;
    logic        bo;
    diff = a - b - bin;
    bo   = (a < b + bin);
    return {bo, diff[7:0]};
  endfunction

  function automatic logic [1:0] ref1(input int unsigned a, input int unsigned b, input int unsigned bin);
    int unsigned diff;
    logic        bo;
    diff = a - b - bin;
    bo   = (a < b + bin);
    return {bo, diff[0]};
  endfunction

  // driver tasks (drive on the falling edge, away from the sampling edge)
  task automatic drive1(input logic v, input logic a, input logic b, input logic bin);
    bus1.in_valid = v;
    bus1.a        = a;
    bus1.b        = b;
    bus1.bin      = bin;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bin);
    bus8.in_valid = v;
    bus8.a        = a;
    bus8.b        = b;
    bus8.bin      = bin;
  endtask

  task automatic idle_both();
    drive1(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic sample_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive1(1'b1, 1'b1, 1'b0, 1'b0);
    drive8(1'b1, 8'h01, 8'h00, 1'b0);
    for (int e = 0; e < 2; e++) begin
      sample_edge();
      vectors++;
      if ({bus1.out_valid, bus1.bout, bus1.d} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset1 edge %0d: got ov/bout/d=%b required 000", e,
                 {bus1.out_valid, bus1.bout, bus1.d});
      end
      vectors++;
      if ({bus8.out_valid, bus8.bout, bus8.d} !== 10'h000) begin
        miscompares++;
        $display("FAIL reset8 edge %0d: got ov/bout/d=%h required 000", e,
                 {bus8.out_valid, bus8.bout, bus8.d});
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    sample_edge();
    vectors++;
    if ({bus1.out_valid, bus1.bout, bus1.d} !== 3'b101) begin
      miscompares++;
      $display("FAIL reset_release1: got ov/bout/d=%b required 101",
               {bus1.out_valid, bus1.bout, bus1.d});
    end
    vectors++;
    if ({bus8.out_valid, bus8.bout, bus8.d} !== {1'b1, 1'b0, 8'h01}) begin
      miscompares++;
      $display("FAIL reset_release8: got ov/bout/d=%h required 201",
               {bus8.out_valid, bus8.bout, bus8.d});
    end
  endtask

  task automatic test_truth_table();
    logic [7:0] d_tbl;
    logic [7:0] b_tbl;
    logic [2:0] combo;
    d_tbl = 8'b1001_0110;
    b_tbl = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      combo = 3'(i);
      drive1(1'b1, combo[2], combo[1], combo[0]);
      drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      sample_edge();
      vectors++;
      if ({bus1.out_valid, bus1.bout, bus1.d} !== {1'b1, b_tbl[i], d_tbl[i]}) begin
        miscompares++;
        $display("FAIL truth_table abc=%b: got ov/bout/d=%b required %b", combo,
                 {bus1.out_valid, bus1.bout, bus1.d}, {1'b1, b_tbl[i], d_tbl[i]});
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    drive1(1'b1, 1'b0, 1'b1, 1'b1);
    sample_edge();
    vectors++;
    if ({bus1.out_valid, bus1.bout, bus1.d} !== 3'b110) begin
      miscompares++;
      $display("FAIL hold_load: got ov/bout/d=%b required 110",
               {bus1.out_valid, bus1.bout, bus1.d});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive1(1'b0, 1'b1, 1'b0, 1'b0);
      sample_edge();
      vectors++;
      if ({bus1.out_valid, bus1.bout, bus1.d} !== 3'b010) begin
        miscompares++;
        $display("FAIL hold cycle %0d: got ov/bout/d=%b required 010", c,
                 {bus1.out_valid, bus1.bout, bus1.d});
      end
    end
  endtask

  task automatic test_boundaries8();
    logic [7:0] ta[4];
    logic [7:0] tb[4];
    logic       tc[4];
    logic [8:0] te[4];
    ta = '{8'h00, 8'h80, 8'h10, 8'h10};
    tb = '{8'hFF, 8'h7F, 8'h10, 8'h10};
    tc = '{1'b1,  1'b0,  1'b0,  1'b1};
    te = '{{1'b1, 8'h00}, {1'b0, 8'h01}, {1'b0, 8'h00}, {1'b1, 8'hFF}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive1(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      drive8(1'b1, ta[i], tb[i], tc[i]);
      sample_edge();
      vectors++;
      if ({bus8.out_valid, bus8.bout, bus8.d} !== {1'b1, te[i]}) begin
        miscompares++;
        $display("FAIL boundary8 %h-%h-%b: got ov/bout/d=%h required %h", ta[i], tb[i], tc[i],
                 {bus8.out_valid, bus8.bout, bus8.d}, {1'b1, te[i]});
      end
    end
  endtask

  // random back-to-back and gapped traffic on both slices, scoreboarded
  task automatic test_random();
    logic [1:0] last1;
    logic [8:0] last8;
    logic       v1, v8, a1, b1, c1, c8;
    logic [7:0] a8, b8;
    logic [2:0] e1, got1;
    logic [9:0] e8, got8;
    last1 = '0;
    last8 = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      v1 = (i == 0) || ($urandom_range(3, 0) != 0);
      v8 = (i == 0) || ($urandom_range(3, 0) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      if (i % 16 == 3) begin a8 = b8; end
      drive1(v1, a1, b1, c1);
      drive8(v8, a8, b8, c8);
      if (v1) last1 = ref1(a1, b1, c1);
      if (v8) last8 = ref8(a8, b8, c8);
      exp1_q.push_back({v1, last1});
      exp8_q.push_back({v8, last8});
      sample_edge();
      e1 = exp1_q.pop_front();
      e8 = exp8_q.pop_front();
      got1 = {bus1.out_valid, bus1.bout, bus1.d};
      got8 = {bus8.out_valid, bus8.bout, bus8.d};
      vectors++;
      if (got1 !== e1) begin
        miscompares++;
        $display("FAIL random1 #%0d: got ov/bout/d=%b required %b", i, got1, e1);
      end
      vectors++;
      if (got8 !== e8) begin
        miscompares++;
        $display("FAIL random8 #%0d: got ov/bout/d=%h required %h", i, got8, e8);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] a8, b8;
    logic       c8;
    logic [9:0] e8, got8;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      drive1(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      drive8(1'b1, a8, b8, c8);
      rst_n = (i != 5);
      if (i == 5) exp8_q.push_back(10'h000);
      else        exp8_q.push_back({1'b1, ref8(a8, b8, c8)});
      sample_edge();
      e8   = exp8_q.pop_front();
      got8 = {bus8.out_valid, bus8.bout, bus8.d};
      vectors++;
      if (got8 !== e8) begin
        miscompares++;
        $display("FAIL reset_midstream #%0d: got ov/bout/d=%h required %h", i, got8, e8);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_both();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle_both();
    test_reset();
    test_truth_table();
    test_hold();
    test_boundaries8();
    test_random();
    test_reset_midstream();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
